// File: rtl/ysyx_22050710_sram_arbiter.sv
// ysyx_22050710_sram_arbiter
// Merges the core's inst port (master 0) and data port (master 1) onto one
// shared SRAM-like memory port (req/addr_ok/data_ok handshakes).
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-low reset
//   i_inst_sram_*          master 0 request (req/op/size/addr/wstrb/wdata)
//   o_inst_sram_*          master 0 handshakes (addr_ok/data_ok) and rdata
//   i_data_sram_*          master 1 request (same set as master 0)
//   o_data_sram_*          master 1 handshakes (addr_ok/data_ok) and rdata
//   o_sram_*               slave request (req/op/size/addr/wstrb/wdata)
//   i_sram_addr_ok/data_ok slave handshakes, i_sram_rdata slave read data
//   o_proto_err            sticky protocol-error flag
//
// Request and response paths are purely combinational. The data master has
// priority, but once an address phase has been offered without addr_ok the
// grant is locked to that master until it is accepted. An in-order FIFO of
// master IDs routes each data_ok back to the master that issued the request.
module ysyx_22050710_sram_arbiter #(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_WMASK_WD = 8,
  parameter int SRAM_DATA_WD  = 64,
  parameter int OT_DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  // master 0: inst
  input  logic                     i_inst_sram_req,
  input  logic                     i_inst_sram_op,
  input  logic [1:0]               i_inst_sram_size,
  input  logic [SRAM_ADDR_WD-1:0]  i_inst_sram_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_inst_sram_wstrb,
  input  logic [SRAM_DATA_WD-1:0]  i_inst_sram_wdata,
  output logic                     o_inst_sram_addr_ok,
  output logic                     o_inst_sram_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_inst_sram_rdata,
  // master 1: data
  input  logic                     i_data_sram_req,
  input  logic                     i_data_sram_op,
  input  logic [1:0]               i_data_sram_size,
  input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wstrb,
  input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
  output logic                     o_data_sram_addr_ok,
  output logic                     o_data_sram_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
  // shared slave port
  output logic                     o_sram_req,
  output logic                     o_sram_op,
  output logic [1:0]               o_sram_size,
  output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
  output logic [SRAM_WMASK_WD-1:0] o_sram_wstrb,
  output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
  input  logic                     i_sram_addr_ok,
  input  logic                     i_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata,
  output logic                     o_proto_err
);

  localparam int PW = $clog2(OT_DEPTH);
  localparam int CW = PW + 1;

  logic          lock_reg;
  logic          lock_id_reg;
  logic          id_mem [OT_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  logic gnt;
  logic gnt_req;
  logic lock_req;
  logic full;
  logic push;
  logic pop;
  logic head_id;

  // A locked grant sticks to the master whose address phase is pending.
  assign gnt      = lock_reg ? lock_id_reg : i_data_sram_req;
  assign gnt_req  = gnt ? i_data_sram_req : i_inst_sram_req;
  assign lock_req = lock_id_reg ? i_data_sram_req : i_inst_sram_req;
  assign full     = (cnt_reg == CW'(OT_DEPTH));

  assign o_sram_req   = gnt_req & ~full;
  assign o_sram_op    = gnt ? i_data_sram_op    : i_inst_sram_op;
  assign o_sram_size  = gnt ? i_data_sram_size  : i_inst_sram_size;
  assign o_sram_addr  = gnt ? i_data_sram_addr  : i_inst_sram_addr;
  assign o_sram_wstrb = gnt ? i_data_sram_wstrb : i_inst_sram_wstrb;
  assign o_sram_wdata = gnt ? i_data_sram_wdata : i_inst_sram_wdata;

  assign push = o_sram_req & i_sram_addr_ok;
  assign pop  = i_sram_data_ok & (cnt_reg != '0);

  assign o_inst_sram_addr_ok = push & ~gnt;
  assign o_data_sram_addr_ok = push & gnt;

  // Responses return in accept order, so the FIFO head names the owner.
  assign head_id             = id_mem[rd_ptr_reg];
  assign o_inst_sram_data_ok = pop & ~head_id;
  assign o_data_sram_data_ok = pop & head_id;

  // Read data is broadcast; each master qualifies it with its own data_ok.
  assign o_inst_sram_rdata = i_sram_rdata;
  assign o_data_sram_rdata = i_sram_rdata;

  assign o_proto_err = err_reg;

  // ID storage has no reset: entries are only read when cnt says they are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      id_mem[wr_ptr_reg] <= gnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      lock_reg    <= 1'b0;
      lock_id_reg <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      // Lock: a master that withdraws its request mid address phase breaks
      // the protocol; drop the lock so the other master is not starved.
      if (lock_reg && !lock_req) begin
        lock_reg <= 1'b0;
        err_reg  <= 1'b1;
      end else if (o_sram_req && !i_sram_addr_ok) begin
        lock_reg    <= 1'b1;
        lock_id_reg <= gnt;
      end else if (push) begin
        lock_reg <= 1'b0;
      end

      if (i_sram_data_ok && cnt_reg == '0) begin
        err_reg <= 1'b1;
      end

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (pop && !push) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule
